// File: rtl/ram_nr1w_repl.sv
// Multi-read single-write RAM: one 1R1W bank per read port, writes broadcast.
// Registered reads with valid, optional write-first bypass, post-reset clear.
module ram_nr1w_repl #(
  parameter int NUM_RD     = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 11,
  parameter bit WR_FIRST   = 1'b1,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [DATA_W-1:0]        w_din,
  input  logic                     w_enb,
  input  logic [NUM_RD-1:0]        r_en,
  input  logic [NUM_RD*ADDR_W-1:0] r_addr,
  output logic [NUM_RD*DATA_W-1:0] r_dout,
  output logic [NUM_RD-1:0]        r_valid,
  output logic                     ready,
  output logic                     w_drop
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;

  logic              bank_we;
  logic [ADDR_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_din;

  // Clear sequencer owns the bank write port until RUN.
  always_comb begin
    bank_we   = w_enb;
    bank_addr = w_addr;
    bank_din  = w_din;
    if (state == CLEAR) begin
      bank_we   = 1'b1;
      bank_addr = clr_cnt;
      bank_din  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLR_ON_RST ? CLEAR : RUN;
      clr_cnt <= '0;
      ready   <= !CLR_ON_RST;
      w_drop  <= 1'b0;
    end else begin
      w_drop <= w_enb && (state == CLEAR);
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
          state <= RUN;
          ready <= 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic [DATA_W-1:0] dout_q;
    logic              valid_q;

    assign ra  = r_addr[k*ADDR_W +: ADDR_W];
    assign hit = WR_FIRST && w_enb && (w_addr == ra);

    always_ff @(posedge clk) begin
      if (bank_we) mem[bank_addr] <= bank_din;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= r_en[k] && ready;
        if (r_en[k] && ready) dout_q <= hit ? w_din : mem[ra];
      end
    end

    assign r_dout[k*DATA_W +: DATA_W] = dout_q;
    assign r_valid[k]                 = valid_q;
  end

endmodule

// File: tb/tb_ram_nr1w_repl.sv
// Bench for ram_nr1w_repl: write-first and read-first instances on shared
// stimulus, checked each cycle against an array model plus literal checks.
module tb_ram_nr1w_repl;

  localparam int NR = 4;
  localparam int AW = 4;
  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [AW-1:0]  w_addr;
  logic [DW-1:0]  w_din;
  logic           w_enb;
  logic [NR-1:0]  r_en;
  logic [NR*AW-1:0] r_addr;

  logic [NR*DW-1:0] dout_a, dout_b;
  logic [NR-1:0]    valid_a, valid_b;
  logic             ready_a, ready_b;
  logic             drop_a, drop_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ram_nr1w_repl #(
    .NUM_RD(NR), .DATA_W(DW), .ADDR_W(AW),
    .WR_FIRST(1'b1), .CLR_ON_RST(1'b1)
  ) u_wf (
    .clk(clk), .rst(rst),
    .w_addr(w_addr), .w_din(w_din), .w_enb(w_enb),
    .r_en(r_en), .r_addr(r_addr),
    .r_dout(dout_a), .r_valid(valid_a),
    .ready(ready_a), .w_drop(drop_a)
  );

  ram_nr1w_repl #(
    .NUM_RD(NR), .DATA_W(DW), .ADDR_W(AW),
    .WR_FIRST(1'b0), .CLR_ON_RST(1'b1)
  ) u_rf (
    .clk(clk), .rst(rst),
    .w_addr(w_addr), .w_din(w_din), .w_enb(w_enb),
    .r_en(r_en), .r_addr(r_addr),
    .r_dout(dout_b), .r_valid(valid_b),
    .ready(ready_b), .w_drop(drop_b)
  );

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: memory array, edge count since reset, expected outputs.
  logic [DW-1:0] m_mem [1<<AW];
  int            m_edges;
  bit            m_ready;
  bit            m_drop;
  logic [NR-1:0] m_valid;
  logic [DW-1:0] m_wf [NR];
  logic [DW-1:0] m_rf [NR];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edges = 0;
      m_ready = 0;
      m_drop  = 0;
      m_valid = '0;
      for (int k = 0; k < NR; k++) begin
        m_wf[k] = '0;
        m_rf[k] = '0;
      end
    end else if (!m_ready) begin
      m_mem[m_edges] = '0;
      m_edges++;
      m_ready = (m_edges == (1 << AW));
      m_drop  = w_enb;
      m_valid = '0;
    end else begin
      m_drop = 0;
      for (int k = 0; k < NR; k++) begin
        logic [AW-1:0] a;
        a = r_addr[k*AW +: AW];
        m_valid[k] = r_en[k];
        if (r_en[k]) begin
          m_rf[k] = m_mem[a];
          m_wf[k] = (w_enb && w_addr == a) ? w_din : m_mem[a];
        end
      end
      if (w_enb) m_mem[w_addr] = w_din;
    end
  end

  always @(negedge clk) begin
    chk("ready_wf", ready_a, m_ready);
    chk("ready_rf", ready_b, m_ready);
    chk("drop_wf", drop_a, m_drop);
    chk("drop_rf", drop_b, m_drop);
    chk("valid_wf", valid_a, m_valid);
    chk("valid_rf", valid_b, m_valid);
    for (int k = 0; k < NR; k++) begin
      chk("dout_wf", dout_a[k*DW +: DW], m_wf[k]);
      chk("dout_rf", dout_b[k*DW +: DW], m_rf[k]);
    end
  end

  task automatic wait_clear(input bit inject);
    int n;
    n = 0;
    while (!ready_a && n < 40) begin
      @(negedge clk);
      n++;
      if (inject) begin
        if (n == 3) begin
          w_enb  = 1'b1;
          w_addr = 4'd2;
          w_din  = 32'h55;
          r_en   = 4'hf;
        end else begin
          w_enb = 1'b0;
          r_en  = '0;
        end
        if (n == 4) chk("drop_pulse", drop_a, 1'b1);
        if (n == 4) chk("clr_no_valid", valid_a, 4'h0);
        if (n == 5) chk("drop_end", drop_a, 1'b0);
      end
    end
    chk("clear_cycles", n, 16);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    w_enb  = 1'b1;
    w_addr = a;
    w_din  = d;
    @(negedge clk);
    w_enb = 1'b0;
  endtask

  task automatic rd(input logic [NR-1:0] en, input logic [NR*AW-1:0] a);
    r_en   = en;
    r_addr = a;
    @(negedge clk);
    r_en = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    w_enb  = 1'b0;
    w_addr = '0;
    w_din  = '0;
    r_en   = '0;
    r_addr = '0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready_a, 1'b0);
    chk("rst_valid", valid_a, 4'h0);
    chk("rst_dout", dout_a, 128'h0);
    chk("rst_drop", drop_a, 1'b0);

    rst = 1'b0;
    wait_clear(1'b1);

    for (int a = 0; a < 16; a++) begin
      logic [AW-1:0] a4;
      a4 = a[AW-1:0];
      rd(4'hf, {4{a4}});
      chk("clr_rd_valid", valid_a, 4'hf);
      chk("clr_rd_data", dout_a, 128'h0);
    end

    wr(4'd5, 32'hDEADBEEF);
    rd(4'hf, {4{4'd5}});
    chk("bcast_data", dout_a, {4{32'hDEADBEEF}});
    chk("bcast_valid", valid_a, 4'hf);

    wr(4'd3, 32'h11);
    w_enb  = 1'b1;
    w_addr = 4'd3;
    w_din  = 32'h22;
    r_en   = 4'h3;
    r_addr = 16'h0003;
    @(negedge clk);
    w_enb = 1'b0;
    r_en  = '0;
    chk("byp_wf", dout_a[31:0], 32'h22);
    chk("byp_rf", dout_b[31:0], 32'h11);
    chk("byp_other", dout_a[63:32], 32'h0);
    rd(4'h1, 16'h0003);
    chk("after_wf", dout_a[31:0], 32'h22);
    chk("after_rf", dout_b[31:0], 32'h22);

    for (int k = 0; k < NR; k++) wr(AW'(k), DW'(k + 100));
    rd(4'hf, {4'd0, 4'd1, 4'd2, 4'd3});
    chk("scale_data", dout_a, {32'd100, 32'd101, 32'd102, 32'd103});
    rd(4'b0101, {4{4'd5}});
    chk("part_valid", valid_a, 4'b0101);
    chk("part_data", dout_a,
        {32'd100, 32'hDEADBEEF, 32'd102, 32'hDEADBEEF});

    r_en   = 4'hf;
    r_addr = {4{4'd5}};
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("run_rst_valid", valid_a, 4'h0);
    chk("run_rst_ready", ready_a, 1'b0);
    chk("run_rst_dout", dout_a, 128'h0);
    @(negedge clk);
    r_en = '0;
    rst  = 1'b0;

    repeat (7) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_clr_ready", ready_a, 1'b0);
    chk("mid_clr_valid", valid_a, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_clear(1'b0);

    rd(4'hf, {4'd5, 4'd2, 4'd3, 4'd5});
    chk("recleared", dout_a, 128'h0);
    chk("recleared_valid", valid_a, 4'hf);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
